// File: rtl/rrq_pkg.sv
// Shared definitions for the rrq_wrr read-request scheduler.
package rrq_pkg;

    // Scheduler states
    localparam logic [0:0] IDLE = 1'b0;
    localparam logic [0:0] BUSY = 1'b1;

    // A zero weight still earns one grant per round
    function automatic int unsigned weight_or_one(input int unsigned w);
        return (w == 0) ? 1 : w;
    endfunction

    // Ceiling log2; clog2(1) = 0
    function automatic int unsigned clog2(input int unsigned v);
        int unsigned r;
        for (r = 0; (32'd1 << r) < v; r++) begin
        end
        return r;
    endfunction

endpackage

// File: rtl/rrq_wrr_if.sv
// Bus between the per-app queues / read engine and the scheduler.
interface rrq_wrr_if #(
    parameter int TOTAL_APPS     = 8,
    parameter int APP_ID_WIDTH   = 3,
    parameter int FIFO_ADD_WIDTH = 10,
    parameter int WEIGHT_WIDTH   = 4
);
    logic [TOTAL_APPS-1:0]              data_queue_empty;
    logic [TOTAL_APPS-1:0]              app_enable;
    logic [TOTAL_APPS*WEIGHT_WIDTH-1:0] weights;
    logic [FIFO_ADD_WIDTH-1:0]          occupants;
    logic [FIFO_ADD_WIDTH-1:0]          occ_threshold;
    logic                               read_done;
    logic [TOTAL_APPS-1:0]              fifo_re;
    logic                               read_queue;
    logic [APP_ID_WIDTH-1:0]            app_id;
    logic                               timeout_pulse;
    logic                               stray_re_err;

    // Scheduler side
    modport master (
        input  data_queue_empty, app_enable, weights, occupants, occ_threshold,
               read_done, fifo_re,
        output read_queue, app_id, timeout_pulse, stray_re_err
    );

    // Queue / read-engine side
    modport slave (
        output data_queue_empty, app_enable, weights, occupants, occ_threshold,
               read_done, fifo_re,
        input  read_queue, app_id, timeout_pulse, stray_re_err
    );
endinterface

// File: rtl/rrq_wrr_rr_pick.sv
// Rotating-priority picker: first requester after ptr, wrapping modulo N.
module rr_pick #(
    parameter int N = 8,
    parameter int W = 3
) (
    input  logic [N-1:0] req,
    input  logic [W-1:0] ptr,
    output logic         found,
    output logic [W-1:0] winner
);
    localparam int unsigned NU = N;

    int unsigned idx;

    // Scan ptr+1 .. ptr+N; the last step revisits ptr itself
    always_comb begin
        found  = 1'b0;
        winner = '0;
        idx    = 0;
        for (int unsigned k = 1; k <= NU; k++) begin
            idx = (32'(ptr) + k) % NU;
            if (!found && req[idx]) begin
                found  = 1'b1;
                winner = W'(idx);
            end
        end
    end
endmodule

// File: rtl/rrq_wrr.sv
// Read-request scheduler: round-robin / weighted round-robin with
// occupancy backpressure, transaction watchdog and stray-read flag.
module rrq_wrr
    import rrq_pkg::*;
#(
    parameter int TOTAL_APPS     = 8,
    parameter int APP_ID_WIDTH   = 3,
    parameter int FIFO_ADD_WIDTH = 10,
    parameter int WEIGHT_WIDTH   = 4,
    parameter int MODE           = 0,
    parameter int TIMEOUT        = 1024
) (
    input logic       clk,
    input logic       rst,
    rrq_wrr_if.master bus
);
    localparam int unsigned WD_RAW = clog2(TIMEOUT + 1);
    localparam int unsigned WD_W   = (WD_RAW < 1) ? 1 : WD_RAW;
    localparam logic [WD_W-1:0] WD_LAST = WD_W'((TIMEOUT == 0) ? 0 : TIMEOUT - 1);

    logic [0:0]              state;
    logic                    rq_q;
    logic [APP_ID_WIDTH-1:0] id_q;
    logic                    to_q;
    logic                    err_q;
    logic [APP_ID_WIDTH-1:0] rr_ptr;
    logic [WEIGHT_WIDTH-1:0] credit;
    logic [WD_W-1:0]         watchdog;

    logic [TOTAL_APPS-1:0]   eligible;
    logic [TOTAL_APPS-1:0]   own_bit;
    logic                    pick_found;
    logic [APP_ID_WIDTH-1:0] pick_winner;
    logic                    hold;
    logic                    can_go;
    logic [APP_ID_WIDTH-1:0] grant_id;
    logic [WEIGHT_WIDTH-1:0] cur_w;

    rr_pick #(
        .N (TOTAL_APPS),
        .W (APP_ID_WIDTH)
    ) u_pick (
        .req    (eligible),
        .ptr    (rr_ptr),
        .found  (pick_found),
        .winner (pick_winner)
    );

    // Eligibility, arbitration decision and the per-app read-strobe mask
    always_comb begin
        eligible = ~bus.data_queue_empty & bus.app_enable;
        hold     = (MODE == 1) && (credit != '0) && eligible[rr_ptr];
        can_go   = (state == IDLE) && pick_found && (bus.occupants < bus.occ_threshold);
        grant_id = hold ? rr_ptr : pick_winner;
        cur_w    = bus.weights[int'(pick_winner)*WEIGHT_WIDTH +: WEIGHT_WIDTH];
        own_bit  = '0;
        own_bit[id_q] = 1'b1;
    end

    // Grant / completion / watchdog FSM with weighted credit bookkeeping
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= IDLE;
            rq_q     <= 1'b0;
            id_q     <= '0;
            to_q     <= 1'b0;
            rr_ptr   <= APP_ID_WIDTH'(TOTAL_APPS - 1);
            credit   <= '0;
            watchdog <= '0;
        end else begin
            to_q <= 1'b0;
            case (state)
                IDLE: begin
                    if (can_go) begin
                        state    <= BUSY;
                        rq_q     <= 1'b1;
                        id_q     <= grant_id;
                        rr_ptr   <= grant_id;
                        watchdog <= '0;
                        if ((MODE == 1) && !hold)
                            credit <= WEIGHT_WIDTH'(weight_or_one(32'(cur_w)));
                    end else if ((credit != '0) && !eligible[rr_ptr]) begin
                        credit <= '0;
                    end
                end
                BUSY: begin
                    if (bus.read_done) begin
                        state <= IDLE;
                        rq_q  <= 1'b0;
                        if (credit != '0)
                            credit <= credit - 1'b1;
                    end else if ((TIMEOUT != 0) && (watchdog == WD_LAST)) begin
                        state  <= IDLE;
                        rq_q   <= 1'b0;
                        to_q   <= 1'b1;
                        credit <= '0;
                    end else if (TIMEOUT != 0) begin
                        watchdog <= watchdog + 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    // Sticky flag for queue reads that do not belong to the granted app
    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            err_q <= 1'b0;
        else if ((state == BUSY) ? |(bus.fifo_re & ~own_bit) : |bus.fifo_re)
            err_q <= 1'b1;
    end

    assign bus.read_queue    = rq_q;
    assign bus.app_id        = id_q;
    assign bus.timeout_pulse = to_q;
    assign bus.stray_re_err  = err_q;
endmodule

// File: tb/tb_rrq_wrr.sv
// Directed bench for rrq_wrr: a MODE 0 instance with a 16-cycle watchdog
// and a MODE 1 instance with the watchdog disabled.
module tb_rrq_wrr;
    logic clk = 1'b0;
    logic rst = 1'b1;
    int   tests = 0;
    int   fails = 0;

    always #5 clk = ~clk;

    rrq_wrr_if #(.TOTAL_APPS(8), .APP_ID_WIDTH(3), .FIFO_ADD_WIDTH(10), .WEIGHT_WIDTH(4)) bus0();
    rrq_wrr_if #(.TOTAL_APPS(8), .APP_ID_WIDTH(3), .FIFO_ADD_WIDTH(10), .WEIGHT_WIDTH(4)) bus1();

    rrq_wrr #(.TOTAL_APPS(8), .APP_ID_WIDTH(3), .FIFO_ADD_WIDTH(10), .WEIGHT_WIDTH(4),
              .MODE(0), .TIMEOUT(16)) dut0 (.clk(clk), .rst(rst), .bus(bus0));
    rrq_wrr #(.TOTAL_APPS(8), .APP_ID_WIDTH(3), .FIFO_ADD_WIDTH(10), .WEIGHT_WIDTH(4),
              .MODE(1), .TIMEOUT(0)) dut1 (.clk(clk), .rst(rst), .bus(bus1));

    typedef struct {
        logic [7:0] empty;
        logic [7:0] enable;
        logic [9:0] occ;
        logic [9:0] thr;
        logic       grant;
        logic [2:0] id;
    } vec_t;

    vec_t vecs[14];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    // Called on a negedge; returns at the first negedge with read_queue high
    task automatic wait_grant(input int which, output int lows, output bit ok);
        ok = 1'b0;
        lows = 0;
        for (int i = 0; i < 40; i++) begin
            if ((which == 0) ? bus0.read_queue : bus1.read_queue) begin
                ok = 1'b1;
                return;
            end
            lows++;
            @(negedge clk);
        end
    endtask

    initial begin
        int lows;
        int hi;
        bit ok;
        logic [2:0] exp_seq1 [8];

        vecs[0]  = '{8'h00, 8'hFF, 10'd0,    10'd1,    1'b1, 3'd0};
        vecs[1]  = '{8'hFF, 8'hFF, 10'd0,    10'd1,    1'b0, 3'd0};
        vecs[2]  = '{8'h00, 8'h00, 10'd0,    10'd1,    1'b0, 3'd0};
        vecs[3]  = '{8'h00, 8'hFF, 10'd500,  10'd500,  1'b0, 3'd0};
        vecs[4]  = '{8'h00, 8'hFF, 10'd499,  10'd500,  1'b1, 3'd1};
        vecs[5]  = '{8'hFE, 8'hFF, 10'd0,    10'd1,    1'b1, 3'd0};
        vecs[6]  = '{8'hD7, 8'hFF, 10'd0,    10'd1,    1'b1, 3'd3};
        vecs[7]  = '{8'h00, 8'h20, 10'd0,    10'd1,    1'b1, 3'd5};
        vecs[8]  = '{8'hFB, 8'hFF, 10'd500,  10'd500,  1'b0, 3'd0};
        vecs[9]  = '{8'hFB, 8'hFF, 10'd499,  10'd500,  1'b1, 3'd2};
        vecs[10] = '{8'hFB, 8'hFF, 10'd0,    10'd1,    1'b1, 3'd2};
        vecs[11] = '{8'h7D, 8'hFF, 10'd0,    10'd1,    1'b1, 3'd7};
        vecs[12] = '{8'h00, 8'hFF, 10'd0,    10'd0,    1'b0, 3'd0};
        vecs[13] = '{8'h00, 8'hFF, 10'd1022, 10'd1023, 1'b1, 3'd0};
        exp_seq1 = '{3'd0, 3'd0, 3'd0, 3'd1, 3'd0, 3'd0, 3'd0, 3'd1};

        bus0.data_queue_empty = '1; bus0.app_enable = '1; bus0.weights = '0;
        bus0.occupants = '0; bus0.occ_threshold = 10'd1023; bus0.read_done = 1'b0; bus0.fifo_re = '0;
        bus1.data_queue_empty = '1; bus1.app_enable = '1; bus1.weights = 32'h0000_0013;
        bus1.occupants = '0; bus1.occ_threshold = 10'd1023; bus1.read_done = 1'b0; bus1.fifo_re = '0;

        // Reset values
        repeat (2) @(negedge clk);
        check("rst_rq0", bus0.read_queue, 0);
        check("rst_id0", bus0.app_id, 0);
        check("rst_to0", bus0.timeout_pulse, 0);
        check("rst_err0", bus0.stray_re_err, 0);
        check("rst_rq1", bus1.read_queue, 0);
        rst = 1'b0;
        @(negedge clk);

        // Table: IDLE evaluations, rr_ptr carried from vector to vector
        for (int v = 0; v < 14; v++) begin
            bus0.data_queue_empty = vecs[v].empty;
            bus0.app_enable       = vecs[v].enable;
            bus0.occupants        = vecs[v].occ;
            bus0.occ_threshold    = vecs[v].thr;
            @(negedge clk);
            check($sformatf("vec%0d_rq", v), bus0.read_queue, vecs[v].grant);
            if (vecs[v].grant)
                check($sformatf("vec%0d_id", v), bus0.app_id, vecs[v].id);
            bus0.data_queue_empty = '1;
            bus0.app_enable       = '1;
            bus0.occupants        = '0;
            bus0.occ_threshold    = 10'd1023;
            if (vecs[v].grant) begin
                bus0.read_done = 1'b1;
                @(negedge clk);
                bus0.read_done = 1'b0;
            end
            @(negedge clk);
        end

        // Reset in the middle of a transaction
        bus0.data_queue_empty = '0;
        wait_grant(0, lows, ok);
        check("mid_grant_ok", ok, 1);
        check("mid_grant_id", bus0.app_id, 1);
        #2 rst = 1'b1;
        #1;
        check("mid_rst_rq", bus0.read_queue, 0);
        check("mid_rst_id", bus0.app_id, 0);
        @(negedge clk);
        rst = 1'b0;

        // Plain round-robin over all eight apps, read_done 3 cycles after grant
        for (int g = 0; g < 9; g++) begin
            wait_grant(0, lows, ok);
            check($sformatf("rr%0d_ok", g), ok, 1);
            check($sformatf("rr%0d_id", g), bus0.app_id, g % 8);
            if (g > 0)
                check($sformatf("rr%0d_gap", g), lows, 1);
            repeat (2) @(negedge clk);
            bus0.read_done = 1'b1;
            if (g == 8)
                bus0.data_queue_empty = '1;
            @(negedge clk);
            bus0.read_done = 1'b0;
        end

        // Watchdog abort on app 4; the aborted app is skipped next round
        bus0.data_queue_empty = 8'hEF;
        wait_grant(0, lows, ok);
        check("to_grant_id", bus0.app_id, 4);
        bus0.data_queue_empty = '0;
        hi = 0;
        for (int i = 0; i < 40; i++) begin
            if (!bus0.read_queue) break;
            hi++;
            @(negedge clk);
        end
        check("to_busy_cycles", hi, 16);
        check("to_rq_low", bus0.read_queue, 0);
        check("to_pulse", bus0.timeout_pulse, 1);
        @(negedge clk);
        check("to_pulse_end", bus0.timeout_pulse, 0);
        check("to_next_rq", bus0.read_queue, 1);
        check("to_next_id", bus0.app_id, 5);

        // read_done in the watchdog's final cycle completes without a pulse
        repeat (15) @(negedge clk);
        check("race_still_busy", bus0.read_queue, 1);
        bus0.read_done = 1'b1;
        bus0.data_queue_empty = '1;
        @(negedge clk);
        bus0.read_done = 1'b0;
        check("race_rq", bus0.read_queue, 0);
        check("race_no_pulse", bus0.timeout_pulse, 0);

        // Stray queue reads during BUSY, then stickiness across a later grant
        check("err_clear", bus0.stray_re_err, 0);
        bus0.data_queue_empty = 8'hF7;
        wait_grant(0, lows, ok);
        check("err_grant_id", bus0.app_id, 3);
        bus0.fifo_re = 8'h08;
        @(negedge clk);
        bus0.fifo_re = '0;
        check("err_own_read", bus0.stray_re_err, 0);
        bus0.fifo_re = 8'h01;
        @(negedge clk);
        bus0.fifo_re = '0;
        check("err_set", bus0.stray_re_err, 1);
        bus0.read_done = 1'b1;
        bus0.data_queue_empty = 8'hFE;
        @(negedge clk);
        bus0.read_done = 1'b0;
        wait_grant(0, lows, ok);
        check("err_next_id", bus0.app_id, 0);
        check("err_sticky", bus0.stray_re_err, 1);
        bus0.read_done = 1'b1;
        bus0.data_queue_empty = '1;
        @(negedge clk);
        bus0.read_done = 1'b0;
        rst = 1'b1;
        #1;
        check("err_rst", bus0.stray_re_err, 0);
        @(negedge clk);
        rst = 1'b0;
        bus0.fifo_re = 8'h80;
        @(negedge clk);
        bus0.fifo_re = '0;
        check("err_idle_read", bus0.stray_re_err, 1);

        // Weighted round-robin: app0 weight 3, app1 weight 1
        bus1.data_queue_empty = 8'hFC;
        for (int g = 0; g < 8; g++) begin
            wait_grant(1, lows, ok);
            check($sformatf("wrr%0d_ok", g), ok, 1);
            check($sformatf("wrr%0d_id", g), bus1.app_id, exp_seq1[g]);
            bus1.read_done = 1'b1;
            if (g == 7)
                bus1.data_queue_empty = '1;
            @(negedge clk);
            bus1.read_done = 1'b0;
        end

        // Credit dropped when the holding app goes empty while IDLE
        bus1.data_queue_empty = 8'hFE;
        wait_grant(1, lows, ok);
        check("cred_grant_id", bus1.app_id, 0);
        bus1.read_done = 1'b1;
        bus1.data_queue_empty = '1;
        @(negedge clk);
        bus1.read_done = 1'b0;
        @(negedge clk);
        bus1.data_queue_empty = 8'hFC;
        @(negedge clk);
        check("cred_clear_rq", bus1.read_queue, 1);
        check("cred_clear_id", bus1.app_id, 1);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: got running, expected finished");
        $fatal(1, "timeout");
    end
endmodule

// File: doc/rrq_wrr.md
Name: rrq_wrr

Overview:
- Parametrised successor read-request scheduler.
- Picks which application data queue is drained next into the shared read path.
- Supports plain round-robin or weighted round-robin, per-app enables, and downstream-occupancy backpressure.
- Adds a watchdog on the read transaction and a sticky error flag for stray FIFO reads.
- Sits between the per-app data queues and the read engine that returns read_done.

Parameters:
TOTAL_APPS, 8, number of application queues (>=2)
APP_ID_WIDTH, 3, width of app_id; must equal clog2(TOTAL_APPS)
FIFO_ADD_WIDTH, 10, width of downstream occupancy count
WEIGHT_WIDTH, 4, per-app weight width
MODE, 0, 0 = plain round-robin, 1 = weighted round-robin
TIMEOUT, 1024, cycles allowed from grant to read_done; 0 disables the watchdog

Ports:
clk  in  1  single clock, rising edge
rst  in  1  reset, asynchronous, active-high
data_queue_empty  in  TOTAL_APPS  bit i high = app i queue empty
app_enable  in  TOTAL_APPS  bit i low = app i excluded from arbitration
weights  in  TOTAL_APPS*WEIGHT_WIDTH  app i weight in slice [i*WEIGHT_WIDTH +: WEIGHT_WIDTH]; 0 treated as 1
occupants  in  FIFO_ADD_WIDTH  downstream FIFO occupancy
occ_threshold  in  FIFO_ADD_WIDTH  grant only when occupants < occ_threshold
read_done  in  1  one-cycle pulse from the read engine: transaction finished
fifo_re  in  TOTAL_APPS  per-app queue read strobes, monitored only
read_queue  out  1  high from grant until done or abort
app_id  out  APP_ID_WIDTH  granted app; valid and stable while read_queue is high
timeout_pulse  out  1  one-cycle pulse on watchdog abort
stray_re_err  out  1  sticky error flag

Behaviour:
- Reset values: all outputs 0; state IDLE; rr_ptr = TOTAL_APPS-1, so the first grant goes to app 0; credit = 0; watchdog = 0.
- Eligible vector: eligible = ~data_queue_empty & app_enable.
- State IDLE:
  - If eligible != 0 and occupants < occ_threshold, arbitrate.
  - On the next clock: read_queue=1, app_id=winner, rr_ptr=winner, watchdog=0, state BUSY.
  - Grant latency is 1 cycle from the eligibility condition.
- Arbitration, MODE 0: winner is the first eligible index scanning rr_ptr+1, rr_ptr+2, ... with wrap-around modulo TOTAL_APPS.
- Arbitration, MODE 1:
  - If credit > 0 and eligible[rr_ptr], re-grant rr_ptr without advancing.
  - Otherwise pick as in MODE 0 and load credit = max(weight[winner],1).
  - Credit decrements by 1 on each read_done.
  - Credit is cleared on timeout abort, or when the current app becomes ineligible while in IDLE.
- State BUSY:
  - read_queue held high; app_id frozen; watchdog increments each cycle.
  - On read_done: read_queue=0 next cycle, state IDLE.
  - IDLE lasts at least 1 cycle, so back-to-back grants are separated by one low cycle of read_queue.
  - If TIMEOUT != 0 and watchdog reaches TIMEOUT-1 without read_done: read_queue=0, timeout_pulse=1 for one cycle, credit=0, rr_ptr stays at the aborted app (it is skipped next round), state IDLE.
- Simultaneous read_done and timeout in the same cycle: read_done wins, no pulse.
- read_done while in IDLE: ignored.
- Inputs changing during BUSY (occupancy, emptiness, enables): no effect until the next IDLE evaluation.
- stray_re_err: set when fifo_re has any bit other than app_id high while in BUSY, or any bit high while in IDLE. Cleared only by rst.
- Reset mid-transaction: all outputs drop to reset values immediately (asynchronous).
- Widths: watchdog is clog2(TIMEOUT+1) bits; credit is WEIGHT_WIDTH bits. No arithmetic overflow is possible.

Decomposition:
- Package rrq_pkg holds:
  - state encoding IDLE=0, BUSY=1;
  - a function returning max(w,1);
  - a clog2 helper constant function.
- Sub-module rr_pick (combinational): inputs request vector and pointer; outputs found flag and winner index (rotating priority). Reused for MODE 0 and the MODE 1 fallback.

Test Plan:
- MODE 0, all 8 apps non-empty and enabled, read_done 3 cycles after each grant -> app_id sequence 0,1,2,...,7,0; read_queue low exactly 1 cycle between grants.
- MODE 1, weights app0=3 and app1=1, only apps 0 and 1 non-empty -> grant sequence 0,0,0,1,0,0,0,1.
- occupants=500, occ_threshold=500, app 2 eligible -> no grant; lower occupants to 499 -> read_queue=1, app_id=2 one cycle later.
- TIMEOUT=16, grant app 4, read_done never arrives -> read_queue falls after 16 BUSY cycles, timeout_pulse high for 1 cycle, next grant goes to app 5 if eligible.
- BUSY on app 3, fifo_re=8'b0000_0001 for one cycle -> stray_re_err=1 and stays high through later grants until rst.
- Assert rst for 1 cycle mid-BUSY -> read_queue=0 and app_id=0 immediately; after release, first grant is app 0.
